pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline hazard controller, successor to the fixed 5-stage stall controller. It takes per-stage stall requests and per-stage redirect (flush) requests and produces three outputs: a per-register stall vector, a per-register bubble/flush vector and a registered PC redirect. Pending redirects are held while a deeper stage is stalled, and a stall watchdog is included. Sits beside the CPU datapath and drives the PC register and every pipeline register.

Parameters:
STAGE_NUM, 5, number of pipeline stages (IF=0 … WB=STAGE_NUM-1); also the stall/flush vector width.
ADDR_W, 32, PC width.
TIMEOUT_W, 8, width of the stall watchdog counter.
STALL_TIMEOUT, 200, consecutive stalled cycles before the watchdog trips (must fit in TIMEOUT_W).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
stall_req_i  in  STAGE_NUM  bit i = stage i requests stall this cycle
redir_req_i  in  STAGE_NUM  bit i = stage i requests redirect (branch mispredict / exception)
redir_pc_i  in  STAGE_NUM*ADDR_W  target PC, slice i for stage i
stall_o  out  STAGE_NUM  bit 0 = hold PC; bit j>0 = hold pipeline register feeding stage j
flush_o  out  STAGE_NUM  bit j = load NOP into register feeding stage j (bit 0 unused, always 0)
new_pc_o  out  ADDR_W  redirect target
new_pc_we_o  out  1  load new_pc_o into PC this cycle
busy_o  out  1  redirect pending
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rstn=0): FSM=RUN; pending target, counters and stall_timeout_o cleared; new_pc_o=0; new_pc_we_o=0. Combinational outputs are all 0 while no requests are present.
- Stall resolution (combinational):
  - k = highest index with stall_req_i[k]=1.
  - stall_o[j]=1 for j ≤ max(k,1), else 0.
  - flush_o[max(k,1)+1]=1 when that index < STAGE_NUM (bubble behind the frozen stage).
  - For 5 stages this matches the legacy patterns: IF/ID → 00011, EX → 00111, MEM → 01111.
- Redirect selection: r = highest index with redir_req_i[r]=1; the oldest instruction wins.
- FSM RUN → PEND → RUN:
  - RUN, redirect request present, no stall request at index > r: next cycle new_pc_we_o=1, new_pc_o=redir_pc_i[r]; in the same request cycle flush_o[j]=1 for all 1 ≤ j ≤ r+1 (j < STAGE_NUM). Stays RUN. Redirect latency: 1 cycle (registered PC write).
  - RUN, redirect request present, stall active at index > r: latch the target and r into the pending registers; go to PEND; busy_o=1.
  - PEND: the requesting stage keeps asserting redir_req_i. When no stall request at index > the latched r remains, issue new_pc_we_o=1 with the latched target and the flushes for that index, then go to RUN.
  - PEND, new redirect request at index > latched r: overwrite the latch.
  - PEND, redirect request at index ≤ latched r: ignored.
- Simultaneous stall and redirect from the same stage: the redirect wins. That stage's stall is ignored for the stall vector; its flushes apply.
- Flush overrides stall on the same register bit (flush_o=1 forces stall_o=0 for that bit).
- Watchdog: the counter increments on each cycle with stall_o[0]=1 and saturates. It clears on any cycle with stall_o[0]=0. On reaching STALL_TIMEOUT, stall_timeout_o goes to 1 and stays there until reset.
- Reset mid-PEND: pending request discarded; no PC write.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cyc_o (32 bits, counts cycles with stall_o[0]=1) and perf_redir_cnt_o (32 bits, counts new_pc_we_o pulses). Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the FSM enum (RUN, PEND);
  - the STAGE_NUM default;
  - localparams for the stage indices (IF_S, ID_S, EX_S, MEM_S, WB_S);
  - Stop/NoStop constants.
- One natural sub-module, prio_enc (parametrised highest-set-bit encoder with valid). It is instantiated twice, once for stall requests and once for redirect requests.

Test Plan:
1. STAGE_NUM=5, stall_req_i=00100 → stall_o=00111, flush_o=01000, new_pc_we_o=0.
2. redir_req_i=00100, redir_pc_i[2]=0x0000_0400, no stall → flush_o=01110 in the request cycle; next cycle new_pc_we_o=1 and new_pc_o=0x400.
3. stall_req_i=01000 held for 3 cycles with redir_req_i=00100 (target 0x80) → busy_o=1 for 3 cycles, then one new_pc_we_o pulse with new_pc_o=0x80.
4. While in PEND, redir_req_i=01000 (target 0x200) arrives → latched target becomes 0x200, and that value is the one issued.
5. stall_req_i=00001 held for 200 cycles → stall_timeout_o rises on cycle 200 and stays 1 after the stall clears; drop rstn → it returns to 0.
6. rstn pulsed low while in PEND → busy_o=0 and no new_pc_we_o pulse afterwards. With PIPE_CTRL_PERF_EN defined, perf_redir_cnt_o reads 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [0:0] {
    Run  = 1'b0,
    Pend = 1'b1
  } state_e;

  localparam int unsigned StageNumDef = 5;

  localparam int unsigned IF_S  = 0;
  localparam int unsigned ID_S  = 1;
  localparam int unsigned EX_S  = 2;
  localparam int unsigned MEM_S = 3;
  localparam int unsigned WB_S  = 4;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the datapath (master) and pipe_ctrl (slave).
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned STAGE_NUM = StageNumDef,
  parameter int unsigned ADDR_W    = 32
);
  logic [STAGE_NUM-1:0]        stall_req_i;
  logic [STAGE_NUM-1:0]        redir_req_i;
  logic [STAGE_NUM*ADDR_W-1:0] redir_pc_i;
  logic [STAGE_NUM-1:0]        stall_o;
  logic [STAGE_NUM-1:0]        flush_o;
  logic [ADDR_W-1:0]           new_pc_o;
  logic                        new_pc_we_o;
  logic                        busy_o;
  logic                        stall_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]                 perf_stall_cyc_o;
  logic [31:0]                 perf_redir_cnt_o;
`endif

  modport master (
    output stall_req_i, redir_req_i, redir_pc_i,
    input  stall_o, flush_o, new_pc_o, new_pc_we_o, busy_o, stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cyc_o, perf_redir_cnt_o
`endif
  );

  modport slave (
    input  stall_req_i, redir_req_i, redir_pc_i,
    output stall_o, flush_o, new_pc_o, new_pc_we_o, busy_o, stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cyc_o, perf_redir_cnt_o
`endif
  );

endinterface

// File: rtl/prio_enc.sv
// Highest-set-bit priority encoder with valid flag.
module prio_enc #(
  parameter int unsigned Width = 5,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req,
  output logic [IdxW-1:0]  idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (req[i]) begin
        idx   = IdxW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush vectors, registered PC redirect, stall watchdog.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STAGE_NUM     = StageNumDef,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned TIMEOUT_W     = 8,
  parameter int unsigned STALL_TIMEOUT = 200
) (
  input logic       clk,
  input logic       rstn,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam logic [TIMEOUT_W-1:0] Limit = TIMEOUT_W'(STALL_TIMEOUT);

  logic [STAGE_NUM-1:0] stall_eff, stall_vec, flush_vec;
  logic [IdxW-1:0]      stall_idx, redir_idx;
  logic                 stall_vld, redir_vld;
  logic [ADDR_W-1:0]    redir_tgt;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      pend_idx_q, pend_idx_d, cand_idx, fire_idx;
  logic [ADDR_W-1:0]    pend_pc_q, pend_pc_d, cand_pc, fire_pc;
  logic [ADDR_W-1:0]    new_pc_q, new_pc_d;
  logic                 new_pc_we_q, fire;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  // A stage redirecting this cycle cannot also hold the pipe.
  assign stall_eff = bus.stall_req_i & ~bus.redir_req_i;
  assign redir_tgt = bus.redir_pc_i[int'(redir_idx)*ADDR_W +: ADDR_W];

  prio_enc #(.Width(STAGE_NUM), .IdxW(IdxW)) u_stall_enc (
    .req   (stall_eff),
    .idx   (stall_idx),
    .valid (stall_vld)
  );

  prio_enc #(.Width(STAGE_NUM), .IdxW(IdxW)) u_redir_enc (
    .req   (bus.redir_req_i),
    .idx   (redir_idx),
    .valid (redir_vld)
  );

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_pc_d  = pend_pc_q;
    fire       = 1'b0;
    fire_idx   = redir_idx;
    fire_pc    = redir_tgt;
    cand_idx   = pend_idx_q;
    cand_pc    = pend_pc_q;
    case (state_q)
      Run: begin
        if (redir_vld) begin
          if (stall_vld && (stall_idx > redir_idx)) begin
            state_d    = Pend;
            pend_idx_d = redir_idx;
            pend_pc_d  = redir_tgt;
          end else begin
            fire = 1'b1;
          end
        end
      end
      Pend: begin
        // An older (deeper) redirect supersedes the latched one.
        if (redir_vld && (redir_idx > pend_idx_q)) begin
          cand_idx = redir_idx;
          cand_pc  = redir_tgt;
        end
        if (stall_vld && (stall_idx > cand_idx)) begin
          pend_idx_d = cand_idx;
          pend_pc_d  = cand_pc;
        end else begin
          fire     = 1'b1;
          fire_idx = cand_idx;
          fire_pc  = cand_pc;
          state_d  = Run;
        end
      end
      default: state_d = Run;
    endcase
    new_pc_d = fire ? fire_pc : new_pc_q;
  end

  always_comb begin
    int unsigned frz;
    frz       = (int'(stall_idx) < ID_S) ? ID_S : int'(stall_idx);
    stall_vec = '0;
    flush_vec = '0;
    for (int unsigned j = 0; j < STAGE_NUM; j++) begin
      if (stall_vld && (j <= frz)) stall_vec[j] = Stop;
      if (stall_vld && (j == frz + 1)) flush_vec[j] = 1'b1;
      if (fire && (j >= 1) && (j <= int'(fire_idx) + 1)) flush_vec[j] = 1'b1;
    end
    flush_vec[IF_S] = 1'b0;
    stall_vec       = stall_vec & ~flush_vec;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_vec[IF_S] == NoStop) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    timeout_d = timeout_q | (stall_vec[IF_S] && (cnt_d >= Limit));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= Run;
      pend_idx_q  <= '0;
      pend_pc_q   <= '0;
      new_pc_q    <= '0;
      new_pc_we_q <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_idx_q  <= pend_idx_d;
      pend_pc_q   <= pend_pc_d;
      new_pc_q    <= new_pc_d;
      new_pc_we_q <= fire;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.stall_o         = stall_vec;
  assign bus.flush_o         = flush_vec;
  assign bus.new_pc_o        = new_pc_q;
  assign bus.new_pc_we_o     = new_pc_we_q;
  assign bus.busy_o          = (state_q == Pend);
  assign bus.stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(stall_vec[IF_S]);
      perf_redir_q <= perf_redir_q + 32'(new_pc_we_q);
    end
  end

  assign bus.perf_stall_cyc_o = perf_stall_q;
  assign bus.perf_redir_cnt_o = perf_redir_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for combinational resolution plus
// hand-written sequences for pending redirects, watchdog and reset.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int unsigned SN = 5;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGE_NUM(SN), .ADDR_W(AW)) bus ();

  pipe_ctrl #(
    .STAGE_NUM     (SN),
    .ADDR_W        (AW),
    .TIMEOUT_W     (8),
    .STALL_TIMEOUT (200)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [SN-1:0] stall;
    logic [SN-1:0] redir;
    logic [SN-1:0] exp_stall;
    logic [SN-1:0] exp_flush;
    logic          exp_we;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t vecs[11];
  int   busy_cnt;
  int   pulses;
  logic [AW-1:0] pc_seen;

  initial begin
    vecs[0]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 32'h0};
    vecs[1]  = '{5'b00001, 5'b00000, 5'b00011, 5'b00100, 1'b0, 32'h0};
    vecs[2]  = '{5'b00010, 5'b00000, 5'b00011, 5'b00100, 1'b0, 32'h0};
    vecs[3]  = '{5'b00100, 5'b00000, 5'b00111, 5'b01000, 1'b0, 32'h0};
    vecs[4]  = '{5'b01000, 5'b00000, 5'b01111, 5'b10000, 1'b0, 32'h0};
    vecs[5]  = '{5'b10000, 5'b00000, 5'b11111, 5'b00000, 1'b0, 32'h0};
    vecs[6]  = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 1'b1, 32'h1000};
    vecs[7]  = '{5'b00000, 5'b10000, 5'b00000, 5'b11110, 1'b1, 32'h5000};
    vecs[8]  = '{5'b00100, 5'b00100, 5'b00000, 5'b01110, 1'b1, 32'h3000};
    vecs[9]  = '{5'b00010, 5'b01000, 5'b00001, 5'b11110, 1'b1, 32'h4000};
    vecs[10] = '{5'b00101, 5'b10010, 5'b00001, 5'b11110, 1'b1, 32'h5000};

    rstn            = 1'b0;
    bus.stall_req_i = '0;
    bus.redir_req_i = '0;
    bus.redir_pc_i  = {32'h5000, 32'h4000, 32'h3000, 32'h2000, 32'h1000};
    #3;
    chk("rst_stall", bus.stall_o, 5'b0);
    chk("rst_flush", bus.flush_o, 5'b0);
    chk("rst_we", bus.new_pc_we_o, 1'b0);
    chk("rst_pc", bus.new_pc_o, 32'h0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_timeout", bus.stall_timeout_o, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();

    // Single-cycle vectors, all resolved in RUN.
    for (int i = 0; i < 11; i++) begin
      bus.stall_req_i = vecs[i].stall;
      bus.redir_req_i = vecs[i].redir;
      #1;
      chk($sformatf("v%0d_stall", i), bus.stall_o, vecs[i].exp_stall);
      chk($sformatf("v%0d_flush", i), bus.flush_o, vecs[i].exp_flush);
      chk($sformatf("v%0d_busy", i), bus.busy_o, 1'b0);
      next_cycle();
      chk($sformatf("v%0d_we", i), bus.new_pc_we_o, vecs[i].exp_we);
      if (vecs[i].exp_we) chk($sformatf("v%0d_pc", i), bus.new_pc_o, vecs[i].exp_pc);
    end
    bus.stall_req_i = '0;
    bus.redir_req_i = '0;
    next_cycle();

    // Redirect at EX from a clear pipe.
    bus.redir_pc_i[2*AW +: AW] = 32'h400;
    bus.redir_req_i = 5'b00100;
    #1;
    chk("redir_flush", bus.flush_o, 5'b01110);
    chk("redir_we_same", bus.new_pc_we_o, 1'b0);
    next_cycle();
    bus.redir_req_i = '0;
    chk("redir_we", bus.new_pc_we_o, 1'b1);
    chk("redir_pc", bus.new_pc_o, 32'h400);
    next_cycle();
    chk("redir_we_once", bus.new_pc_we_o, 1'b0);

    // Redirect held behind a MEM stall for three cycles.
    bus.redir_pc_i[2*AW +: AW] = 32'h80;
    bus.stall_req_i = 5'b01000;
    bus.redir_req_i = 5'b00100;
    busy_cnt = 0;
    pulses   = 0;
    pc_seen  = '0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) bus.stall_req_i = '0;
      if (c == 4) bus.redir_req_i = '0;
      #1;
      if (c == 0) begin
        chk("pend_stall", bus.stall_o, 5'b01111);
        chk("pend_flush0", bus.flush_o, 5'b10000);
      end
      if (c == 3) chk("pend_fire_flush", bus.flush_o, 5'b01110);
      busy_cnt += int'(bus.busy_o);
      if (bus.new_pc_we_o) begin
        pulses++;
        pc_seen = bus.new_pc_o;
      end
      next_cycle();
    end
    chk("pend_busy_cycles", busy_cnt, 3);
    chk("pend_pulses", pulses, 1);
    chk("pend_pc", pc_seen, 32'h80);

    // Deeper redirect overwrites the latch while pending.
    bus.redir_pc_i[3*AW +: AW] = 32'h200;
    bus.stall_req_i = 5'b10000;
    bus.redir_req_i = 5'b00100;
    next_cycle();
    chk("ovr_busy", bus.busy_o, 1'b1);
    bus.redir_req_i = 5'b01100;
    next_cycle();
    chk("ovr_busy2", bus.busy_o, 1'b1);
    chk("ovr_we_hold", bus.new_pc_we_o, 1'b0);
    bus.stall_req_i = '0;
    #1;
    chk("ovr_flush", bus.flush_o, 5'b11110);
    next_cycle();
    bus.redir_req_i = '0;
    chk("ovr_we", bus.new_pc_we_o, 1'b1);
    chk("ovr_pc", bus.new_pc_o, 32'h200);
    chk("ovr_busy_done", bus.busy_o, 1'b0);
    next_cycle();

    // Watchdog: IF stall for 200 consecutive cycles.
    bus.stall_req_i = 5'b00001;
    #1;
    chk("wd_stall", bus.stall_o, 5'b00011);
    chk("wd_flush", bus.flush_o, 5'b00100);
    repeat (199) @(posedge clk);
    #1;
    chk("wd_before", bus.stall_timeout_o, 1'b0);
    next_cycle();
    chk("wd_trip", bus.stall_timeout_o, 1'b1);
    bus.stall_req_i = '0;
    next_cycle();
    next_cycle();
    chk("wd_sticky", bus.stall_timeout_o, 1'b1);
    rstn = 1'b0;
    #1;
    chk("wd_reset", bus.stall_timeout_o, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();

    // Reset while pending discards the request.
    bus.stall_req_i = 5'b10000;
    bus.redir_req_i = 5'b00010;
    next_cycle();
    chk("rp_busy", bus.busy_o, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rp_busy_rst", bus.busy_o, 1'b0);
    bus.stall_req_i = '0;
    bus.redir_req_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      pulses += int'(bus.new_pc_we_o);
    end
    chk("rp_no_pulse", pulses, 0);
    chk("rp_busy_after", bus.busy_o, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rp_perf_redir", bus.perf_redir_cnt_o, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
